// File: rtl/otter_pkg.sv
// Shared OTTER definitions: opcode encodings, control-unit states and the
// funct3 values the sequencer needs to tell SYSTEM instructions apart.
package otter_pkg;

   // RV32I major opcodes, shared with the combinational decoder.
   typedef enum logic [6:0] {
      LUI    = 7'b0110111,
      AUIPC  = 7'b0010111,
      JAL    = 7'b1101111,
      JALR   = 7'b1100111,
      BRANCH = 7'b1100011,
      LOAD   = 7'b0000011,
      STORE  = 7'b0100011,
      OP_IMM = 7'b0010011,
      OP     = 7'b0110011,
      SYS    = 7'b1110011
   } opcode_t;

   // Sequencer states: boot, fetch, execute, load writeback, trap entry.
   typedef enum logic [2:0] {
      ST_INIT,
      ST_FETCH,
      ST_EXEC,
      ST_WB,
      ST_INTR
   } cu_state_t;

   // funct3 values that select between the SYSTEM instructions we support.
   localparam logic [2:0] F3_CSRRW = 3'b001;
   localparam logic [2:0] F3_MRET  = 3'b000;

   // Loads are the only instructions that need a separate writeback cycle.
   function automatic logic isLoad(input logic [6:0] opcode);
      return opcode == LOAD;
   endfunction

endpackage

// File: rtl/cu_fsm_if.sv
// Bundle between the sequencer and the rest of the core: the interrupt
// request and IR fields coming in, the per-cycle enables going out.
interface cu_fsm_if;

   logic       intr;
   logic [6:0] ir6_0;
   logic [2:0] ir14_12;

   logic       pcWrite;
   logic       regWrite;
   logic       memWE2;
   logic       memRDEN1;
   logic       memRDEN2;
   logic       reset;
   logic       csr_WE;
   logic       int_taken;
   logic       mret_exec;

   // The sequencer reads the IR and interrupt line and drives every enable.
   modport master (
      input  intr, ir6_0, ir14_12,
      output pcWrite, regWrite, memWE2, memRDEN1, memRDEN2,
             reset, csr_WE, int_taken, mret_exec
   );

   // The datapath side supplies the IR and interrupt line and obeys the enables.
   modport slave (
      output intr, ir6_0, ir14_12,
      input  pcWrite, regWrite, memWE2, memRDEN1, memRDEN2,
             reset, csr_WE, int_taken, mret_exec
   );

endinterface

// File: rtl/cu_fsm.sv
// Multicycle sequencer for the OTTER RV32I core. It walks each instruction
// through fetch, execute, an optional load writeback and optional interrupt
// entry, and decides in which cycle the decoder's selects actually commit.
module cu_fsm
   import otter_pkg::*;
#(
   parameter bit INTR_EN = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   cu_fsm_if.master    bus
);

   cu_state_t state_q;
   cu_state_t state_d;
   logic      intrReq;

   // With INTR_EN cleared the request is tied off, so ST_INTR can never be entered.
   assign intrReq = bus.intr && INTR_EN;

   // State register; reset is synchronous so a mid-instruction reset simply lands in ST_INIT.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and enables; everything defaults low and RST overrides all states so no partial write can leak.
   always_comb begin
      state_d       = state_q;
      bus.pcWrite   = 1'b0;
      bus.regWrite  = 1'b0;
      bus.memWE2    = 1'b0;
      bus.memRDEN1  = 1'b0;
      bus.memRDEN2  = 1'b0;
      bus.reset     = 1'b0;
      bus.csr_WE    = 1'b0;
      bus.int_taken = 1'b0;
      bus.mret_exec = 1'b0;

      if (RST) begin
         bus.reset = 1'b1;
         state_d   = ST_INIT;
      end else begin
         case (state_q)
            ST_INIT: begin
               bus.reset = 1'b1;
               state_d   = ST_FETCH;
            end

            ST_FETCH: begin
               bus.memRDEN1 = 1'b1;
               state_d      = ST_EXEC;
            end

            ST_EXEC: begin
               state_d = intrReq ? ST_INTR : ST_FETCH;
               case (bus.ir6_0)
                  OP, OP_IMM, LUI, AUIPC, JAL, JALR: begin
                     bus.pcWrite  = 1'b1;
                     bus.regWrite = 1'b1;
                  end
                  LOAD: begin
                     bus.memRDEN2 = 1'b1;
                     state_d      = ST_WB;
                  end
                  STORE: begin
                     bus.memWE2  = 1'b1;
                     bus.pcWrite = 1'b1;
                  end
                  BRANCH: begin
                     bus.pcWrite = 1'b1;
                  end
                  SYS: begin
                     bus.pcWrite = 1'b1;
                     if (bus.ir14_12 == F3_CSRRW) begin
                        bus.regWrite = 1'b1;
                        bus.csr_WE   = 1'b1;
                     end else if (bus.ir14_12 == F3_MRET) begin
                        bus.mret_exec = 1'b1;
                     end
                  end
                  default: begin
                     bus.pcWrite = 1'b1;
                  end
               endcase
            end

            ST_WB: begin
               bus.regWrite = 1'b1;
               bus.pcWrite  = 1'b1;
               state_d      = intrReq ? ST_INTR : ST_FETCH;
            end

            ST_INTR: begin
               bus.int_taken = 1'b1;
               bus.pcWrite   = 1'b1;
               state_d       = ST_FETCH;
            end

            default: begin
               state_d = ST_INIT;
            end
         endcase
      end
   end

   // The instruction port, data read and data write never share a cycle.
   assert property (@(posedge CLK) $onehot0({bus.memWE2, bus.memRDEN1, bus.memRDEN2}));

   // Trap entry and trap return are distinct cycles.
   assert property (@(posedge CLK) !(bus.int_taken && bus.mret_exec));

   // A load must not commit its read and its writeback in the same cycle.
   assert property (@(posedge CLK) !(bus.memRDEN2 && bus.regWrite));

endmodule
